// File: rtl/box_v_3_window_sequencer.sv
// rtl/box_v_3_window_sequencer.sv - raster to vertical 3x1 window sequencer with border padding and flush
module box_v_3_window_sequencer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [9:0]            pixel_i,
  input  logic                  valid_i,
  input  logic                  sof_i,
  output logic                  ready_o,
  output logic [2:0][0:0][9:0]  window_o,
  output logic [15:0]           col_o,
  output logic [15:0]           row_o,
  output logic                  valid_o,
  output logic                  frame_done_o
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW-1:0] C_LAST = AW'(WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] c;
  logic [RW-1:0] r;
  logic [AW-1:0] fc;

  // lb0 holds the previous row, lb1 the row before that
  logic [9:0] lb0 [WIDTH];
  logic [9:0] lb1 [WIDTH];

  logic          accept;
  logic [AW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic [AW-1:0] rd_addr;
  logic [9:0]    lb0_rd;
  logic [9:0]    lb1_rd;

  assign ready_o = (state != FLUSH);
  assign accept  = valid_i && ready_o;

  // sof relocates the accepted pixel to the frame origin
  assign cur_c   = sof_i ? '0 : c;
  assign cur_r   = sof_i ? '0 : r;
  assign rd_addr = (state == FLUSH) ? fc : cur_c;
  assign lb0_rd  = lb0[rd_addr];
  assign lb1_rd  = lb1[rd_addr];

  // Shift the column through both line buffers on every accepted pixel
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[cur_c] <= lb0_rd;
      lb0[cur_c] <= pixel_i;
    end
  end

  // Position tracking, fill/run/flush sequencing and registered window outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= FILL;
      c            <= '0;
      r            <= '0;
      fc           <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      window_o     <= '0;
      col_o        <= '0;
      row_o        <= '0;
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        FILL, RUN: begin
          if (accept) begin
            if (!sof_i && state == RUN) begin
              valid_o        <= 1'b1;
              // first output row has no row above it: pad with zero
              window_o[0][0] <= (r == RW'(1)) ? 10'd0 : lb1_rd;
              window_o[1][0] <= lb0_rd;
              window_o[2][0] <= pixel_i;
              col_o          <= 16'(c);
              row_o          <= 16'(r) - 16'd1;
            end
            if (cur_c == C_LAST) begin
              c <= '0;
              if (cur_r == R_LAST) begin
                state <= FLUSH;
                fc    <= '0;
                r     <= '0;
              end else begin
                r     <= cur_r + RW'(1);
                state <= RUN;
              end
            end else begin
              c <= cur_c + AW'(1);
              r <= cur_r;
              if (sof_i) begin
                state <= FILL;
              end
            end
          end
        end
        FLUSH: begin
          // bottom image row: no row below it, pad with zero
          valid_o        <= 1'b1;
          window_o[0][0] <= lb1_rd;
          window_o[1][0] <= lb0_rd;
          window_o[2][0] <= 10'd0;
          col_o          <= 16'(fc);
          row_o          <= 16'(HEIGHT - 1);
          if (fc == C_LAST) begin
            frame_done_o <= 1'b1;
            state        <= FILL;
            fc           <= '0;
            c            <= '0;
            r            <= '0;
          end else begin
            fc <= fc + AW'(1);
          end
        end
        default: begin
          state <= FILL;
          c     <= '0;
          r     <= '0;
          fc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_v_3_window_sequencer.sv
// tb/tb_box_v_3_window_sequencer.sv - self-checking bench for box_v_3_window_sequencer
module tb_box_v_3_window_sequencer;

  localparam int W = 4;
  localparam int H = 3;

  logic                 clk_i;
  logic                 rst_ni;
  logic [9:0]           pixel_i;
  logic                 valid_i;
  logic                 sof_i;
  logic                 ready_o;
  logic [2:0][0:0][9:0] window_o;
  logic [15:0]          col_o;
  logic [15:0]          row_o;
  logic                 valid_o;
  logic                 frame_done_o;

  box_v_3_window_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pixel_i      (pixel_i),
    .valid_i      (valid_i),
    .sof_i        (sof_i),
    .ready_o      (ready_o),
    .window_o     (window_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o)
  );

  typedef struct {
    logic [9:0] top;
    logic [9:0] mid;
    logic [9:0] bot;
    int         col;
    int         row;
    logic       done;
  } exp_t;

  typedef struct {
    logic       vin;
    logic       sof;
    logic [9:0] pix;
    logic       exp_ready;
    logic       exp_out;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_acc = 0;
  int   last_acc = 0;
  int   vcount = 0;
  int   last_span = 0;
  int   done_cnt = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // output monitor: every window must match the head of the scoreboard
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      vcount = 0;
    end else if (valid_o || frame_done_o) begin
      if (valid_o) vcount = vcount + 1;
      if (frame_done_o) begin
        done_cnt  = done_cnt + 1;
        last_span = vcount;
        vcount    = 0;
      end
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_out got v=%0b win=%0d,%0d,%0d col=%0d row=%0d done=%0b need no output",
                 valid_o, window_o[0][0], window_o[1][0], window_o[2][0], col_o, row_o, frame_done_o);
      end else begin
        me = sb.pop_front();
        if (!valid_o || window_o[0][0] !== me.top || window_o[1][0] !== me.mid ||
            window_o[2][0] !== me.bot || col_o !== me.col[15:0] || row_o !== me.row[15:0] ||
            frame_done_o !== me.done) begin
          bad = bad + 1;
          $display("FAIL window got v=%0b win=%0d,%0d,%0d col=%0d row=%0d done=%0b need v=1 win=%0d,%0d,%0d col=%0d row=%0d done=%0b",
                   valid_o, window_o[0][0], window_o[1][0], window_o[2][0], col_o, row_o, frame_done_o,
                   me.top, me.mid, me.bot, me.col, me.row, me.done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int need);
    total = total + 1;
    if (got != need) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  function automatic logic [9:0] pv(input int mode, input int r, input int c);
    if (mode == 0) return 10'(16 * r + c);
    if (r == 1) return (c % 2 == 0) ? 10'd1023 : 10'd0;
    return 10'((r * 37 + c * 101 + 5) % 1024);
  endfunction

  task automatic send_pixel(input logic [9:0] p, input logic sof);
    int n = 0;
    valid_i = 1'b1;
    pixel_i = p;
    sof_i   = sof;
    while (!ready_o && n < 64) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!ready_o) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL ready_timeout got ready=0 need ready=1 within 64 cycles");
    end
    acc_cyc = cyc;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gaps, input int npix, input bit push_flush);
    logic [9:0] img [H][W];
    exp_t x;
    logic [9:0] p;
    int k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k < npix) begin
          p = pv(mode, r, c);
          img[r][c] = p;
          if (r >= 1) begin
            x.top  = (r == 1) ? 10'd0 : img[r-2][c];
            x.mid  = img[r-1][c];
            x.bot  = p;
            x.col  = c;
            x.row  = r - 1;
            x.done = 1'b0;
            sb.push_back(x);
          end
          if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk_i); #1;
            end
          end
          send_pixel(p, (k == 0));
          if (k == 0) first_acc = acc_cyc;
          k++;
        end
      end
    end
    last_acc = acc_cyc;
    if (push_flush && npix == W * H) begin
      for (int fc = 0; fc < W; fc++) begin
        x.top  = img[H-2][fc];
        x.mid  = img[H-1][fc];
        x.bot  = 10'd0;
        x.col  = fc;
        x.row  = H - 1;
        x.done = (fc == W - 1);
        sb.push_back(x);
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  vec_t tbl [16];
  int   d0;
  int   t_last;

  initial begin
    // first frame as a vector table: 12 pixels then 4 flush cycles
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        tbl[i].vin       = 1'b1;
        tbl[i].sof       = (i == 0);
        tbl[i].pix       = 10'(16 * (i / W) + (i % W));
        tbl[i].exp_ready = 1'b1;
        tbl[i].exp_out   = ((i / W) >= 1);
        tbl[i].e.top     = ((i / W) <= 1) ? 10'd0 : 10'(16 * ((i / W) - 2) + (i % W));
        tbl[i].e.mid     = ((i / W) == 0) ? 10'd0 : 10'(16 * ((i / W) - 1) + (i % W));
        tbl[i].e.bot     = 10'(16 * (i / W) + (i % W));
        tbl[i].e.col     = i % W;
        tbl[i].e.row     = (i / W) - 1;
        tbl[i].e.done    = 1'b0;
      end else begin
        tbl[i].vin       = 1'b0;
        tbl[i].sof       = 1'b0;
        tbl[i].pix       = 10'd0;
        tbl[i].exp_ready = 1'b0;
        tbl[i].exp_out   = 1'b1;
        tbl[i].e.top     = 10'(16 + (i - 12));
        tbl[i].e.mid     = 10'(32 + (i - 12));
        tbl[i].e.bot     = 10'd0;
        tbl[i].e.col     = i - 12;
        tbl[i].e.row     = 2;
        tbl[i].e.done    = (i == 15);
      end
    end

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    pixel_i = 10'd0;
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    check("rst_valid", valid_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_window", int'(window_o), 0);
    check("rst_col", col_o, 0);
    check("rst_row", row_o, 0);
    rst_ni = 1'b1;
    #1;
    check("rst_ready", ready_o, 1);
    @(posedge clk_i); #1;

    for (int i = 0; i < 16; i++) begin
      valid_i = tbl[i].vin;
      sof_i   = tbl[i].sof;
      pixel_i = tbl[i].pix;
      check($sformatf("tbl%0d_ready", i), ready_o, tbl[i].exp_ready);
      if (tbl[i].exp_out) sb.push_back(tbl[i].e);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    sof_i   = 1'b0;
    check("ready_after_flush", ready_o, 1);
    wait_drain();
    check("frame1_done_cnt", done_cnt, 1);
    check("frame1_span", last_span, W * H);

    // extremes in row 1 with random input gaps
    send_frame(1, 1'b1, W * H, 1'b1);
    wait_drain();
    check("gap_done_cnt", done_cnt, 2);
    check("gap_span", last_span, W * H);

    // abort at (2,1), then a full new frame
    d0 = done_cnt;
    send_frame(1, 1'b0, W + 2, 1'b0);
    send_frame(0, 1'b0, W * H, 1'b1);
    wait_drain();
    check("abort_done_cnt", done_cnt, d0 + 1);

    // reset during the second flush cycle
    d0 = done_cnt;
    send_frame(0, 1'b0, W * H, 1'b0);
    @(posedge clk_i); #1;
    check("flush0_valid", valid_o, 1);
    check("flush0_top", window_o[0][0], 16);
    check("flush0_ready", ready_o, 0);
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_done", frame_done_o, 0);
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1;
    #1;
    check("midrst_ready", ready_o, 1);
    check("midrst_sb_empty", sb.size(), 0);
    send_frame(0, 1'b0, W * H, 1'b1);
    wait_drain();
    check("midrst_done_cnt", done_cnt, d0 + 1);
    check("midrst_span", last_span, W * H);

    // back-to-back frames
    d0 = done_cnt;
    send_frame(0, 1'b0, W * H, 1'b1);
    t_last = last_acc;
    send_frame(0, 1'b0, W * H, 1'b1);
    check("b2b_gap_cycles", first_acc - t_last, W + 1);
    wait_drain();
    check("b2b_done_cnt", done_cnt, d0 + 2);
    check("b2b_span", last_span, W * H);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_v_3_window_sequencer.md
Name: box_v_3_window_sequencer

Overview:
- Converts a raster stream of 10-bit pixels into the vertical 3x1 windows, with col/row/valid, that feed custom_box_v_3_uint10_to_uint12.
- Holds two line buffers and tracks column/row position.
- Applies zero padding at the top and bottom frame borders.
- Runs a flush phase after the last input row so the bottom image row is still emitted.
- Sits between the pixel source and the box-filter datapath; one window per cycle, no output backpressure.

Parameters:
WIDTH, 640, pixels per row (>=2)
HEIGHT, 480, rows per frame (>=2)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
pixel_i  input  10  input pixel, raster order
valid_i  input  1  pixel_i valid
sof_i  input  1  start of frame; qualified by valid_i
ready_o  output  1  sequencer accepts a pixel this cycle
window_o  output  10x[3][1]  [0][0]=row-1, [1][0]=centre row, [2][0]=row+1
col_o  output  16  centre column
row_o  output  16  centre row
valid_o  output  1  window_o/col_o/row_o valid
frame_done_o  output  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (rst_ni=0, async):
  - valid_o=0, frame_done_o=0, window_o/col_o/row_o=0.
  - Counters c=0, r=0; state FILL; ready_o=1 after release.
  - Line buffer contents are don't-care and are never observed (top pad is forced).
- Accept: valid_i && ready_o. Non-accepted cycles change nothing and give valid_o=0 next cycle.
- sof_i on an accepted pixel forces that pixel to (c=0, r=0) and enters FILL. This discards a partial frame with no flush and no frame_done_o.
- Counters on accept: c increments; at c=WIDTH-1, c wraps to 0 and r increments.
- Line buffers lb0 (previous row) and lb1 (two rows back), WIDTH x 10 each.
  - On accept at column c: read lb1[c] and lb0[c] (old values), then write lb1[c]<=lb0[c] and lb0[c]<=pixel_i.
- States:
  - FILL (r==0): accepts fill lb0 only; no output; last pixel of row 0 -> RUN.
  - RUN (1<=r<=HEIGHT-1): each accept at (c,r) registers, visible next cycle:
    - window = {top: (r==1 ? 0 : lb1[c]), mid: lb0[c], bot: pixel_i}
    - col_o=c, row_o=r-1, valid_o=1
    - Accepting (WIDTH-1, HEIGHT-1) -> FLUSH, flush column fc=0.
  - FLUSH: ready_o=0 for exactly WIDTH cycles. Each cycle registers:
    - window = {lb1[fc], lb0[fc], 0}
    - col_o=fc, row_o=HEIGHT-1, valid_o=1
    - fc increments; frame_done_o=1 registered with fc=WIDTH-1; then -> FILL with c=r=0.
- ready_o is combinational: 1 in FILL/RUN, 0 in FLUSH.
- Latency: accepted pixel -> window output 1 cycle. Last accept -> frame_done_o is WIDTH+1 cycles.
- Values pass unmodified, including 0 and 1023; no arithmetic on data.
- col_o/row_o are zero-extended to 16 bits.
- Reset mid-FLUSH: remaining flush outputs are abandoned; valid_o=0 immediately (async).
- valid_i gaps inside a row are tolerated; the counters hold position.

Test Plan:
- WIDTH=4, HEIGHT=3, pixel=16r+c, continuous valid, sof_i on first pixel:
  - No valid_o during row 0.
  - Accept (2,1)=18 -> next cycle window {0,2,18}, col 2, row 0.
  - Accept (1,2)=33 -> window {1,17,33}, col 1, row 1.
- Flush, same frame: accept (3,2)=35 at cycle T.
  - T+1: window {3,19,35}, row 1; ready_o=0 for T+1..T+4.
  - T+2..T+5: windows {16+fc, 32+fc, 0}, row 2, col 0..3.
  - frame_done_o=1 only at T+5; ready_o=1 at T+5.
- Pixels 1023 and 0 at row 1 with random valid_i gaps:
  - Exactly WIDTH*(HEIGHT-1) RUN windows, values intact, col/row unaffected by gaps.
- Abort: sof_i asserted at (2,1) mid-frame, then a full new frame:
  - No frame_done_o for the aborted frame.
  - New frame row-0 outputs start with a zero top pad.
- rst_ni low at the 2nd flush cycle:
  - valid_o=0 and frame_done_o=0 immediately; ready_o=1 after release.
  - The next frame output matches the first scenario.
- Back-to-back frames:
  - Second frame's first pixel accepted the cycle ready_o returns high.
  - Outputs are identical to the first frame; the count of valid_o between frame_done_o pulses equals WIDTH*HEIGHT (12).
